// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter and its requesters.
package sram_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_type;

   localparam int REQ_UART = 0;
   localparam int REQ_M1   = 1;
   localparam int REQ_M2   = 2;
   localparam int REQ_VGA  = 3;

   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 16;

endpackage

// File: rtl/sram_arb_read_pipe.sv
// Carries {valid, tag} for each issued SRAM access across the read latency
// and decodes the emerging tag into a one-hot read-valid pulse.
module sram_arb_read_pipe #(
   parameter int NUM_REQ      = 4,
   parameter int READ_LATENCY = 2,
   parameter int TAG_W        = 2
) (
   input  logic               CLOCK_50_I,
   input  logic               resetn,
   input  logic               push_valid,
   input  logic [TAG_W-1:0]   push_tag,
   output logic [NUM_REQ-1:0] rd_valid,
   output logic               busy
);

   logic [READ_LATENCY-1:0]            vld;
   logic [READ_LATENCY-1:0][TAG_W-1:0] tag;

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         vld <= '0;
         tag <= '0;
      end else begin
         vld[0] <= push_valid;
         tag[0] <= push_tag;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld[i] <= vld[i-1];
            tag[i] <= tag[i-1];
         end
      end
   end

   always_comb begin
      rd_valid = '0;
      if (vld[READ_LATENCY-1])
         rd_valid[tag[READ_LATENCY-1]] = 1'b1;
   end

   assign busy = |vld;

endmodule

// File: rtl/sram_access_arbiter.sv
// Fixed-priority, burst-locked arbiter sharing one SRAM_Controller port among
// up to four requesters; read data is routed back by tag READ_LATENCY cycles later.
module sram_access_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int READ_LATENCY = 2,
   parameter int MAX_BURST    = 0
) (
   input  logic                                   CLOCK_50_I,
   input  logic                                   resetn,
   input  logic [NUM_REQ-1:0]                     req_i,
   input  logic [NUM_REQ-1:0]                     req_we_n_i,
   input  logic [NUM_REQ-1:0][SRAM_ADDR_W-1:0]    req_address_i,
   input  logic [NUM_REQ-1:0][SRAM_DATA_W-1:0]    req_write_data_i,
   output logic [NUM_REQ-1:0]                     gnt_o,
   output logic [NUM_REQ-1:0]                     rd_valid_o,
   output logic [SRAM_DATA_W-1:0]                 rd_data_o,
   output logic [SRAM_ADDR_W-1:0]                 SRAM_address_o,
   output logic [SRAM_DATA_W-1:0]                 SRAM_write_data_o,
   output logic                                   SRAM_we_n_o,
   input  logic [SRAM_DATA_W-1:0]                 SRAM_read_data_i,
   output logic [1:0]                             owner_o,
   output logic                                   busy_o
);

   localparam int IDX_W = 2;
   localparam int CNT_W = (MAX_BURST < 2) ? 2 : $clog2(MAX_BURST + 1);

   arb_state_type      state, state_next;
   logic [NUM_REQ-1:0] gnt, gnt_next;
   logic [NUM_REQ-1:0] force_mask, mask_next;
   logic [NUM_REQ-1:0] cand;
   logic [IDX_W-1:0]   owner, owner_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               issue;
   logic               limit_hit;
   logic               pipe_busy;

   assign limit_hit = (MAX_BURST != 0) && (cnt == CNT_W'(MAX_BURST));

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state      <= ARB_IDLE;
         gnt        <= '0;
         force_mask <= '0;
         owner      <= '0;
         cnt        <= '0;
      end else begin
         state      <= state_next;
         gnt        <= gnt_next;
         force_mask <= mask_next;
         owner      <= owner_next;
         cnt        <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      gnt_next   = gnt;
      mask_next  = force_mask;
      owner_next = owner;
      cnt_next   = cnt;
      issue      = 1'b0;
      cand       = req_i & ~force_mask;
      case (state)
         ARB_IDLE: begin
            // The mask from a forced release applies to exactly one arbitration.
            mask_next = '0;
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
               if (cand[i]) begin
                  gnt_next   = NUM_REQ'(1) << i;
                  owner_next = IDX_W'(i);
               end
            end
            if (|cand) begin
               state_next = ARB_OWNED;
               cnt_next   = '0;
            end
         end
         ARB_OWNED: begin
            if (!(|(req_i & gnt))) begin
               gnt_next   = '0;
               state_next = ARB_IDLE;
            end else if (limit_hit && (|(req_i & ~gnt))) begin
               gnt_next   = '0;
               state_next = ARB_IDLE;
               mask_next  = gnt;
            end else begin
               issue = 1'b1;
               if (cnt != '1)
                  cnt_next = cnt + CNT_W'(1);
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   // Bus carries idle values whenever no access is issued, including drop/force cycles.
   assign SRAM_address_o    = issue ? req_address_i[owner]    : '0;
   assign SRAM_write_data_o = issue ? req_write_data_i[owner] : '0;
   assign SRAM_we_n_o       = issue ? req_we_n_i[owner]       : 1'b1;

   sram_arb_read_pipe #(
      .NUM_REQ      (NUM_REQ),
      .READ_LATENCY (READ_LATENCY),
      .TAG_W        (IDX_W)
   ) u_read_pipe (
      .CLOCK_50_I (CLOCK_50_I),
      .resetn     (resetn),
      .push_valid (issue && req_we_n_i[owner]),
      .push_tag   (owner),
      .rd_valid   (rd_valid_o),
      .busy       (pipe_busy)
   );

   assign rd_data_o = SRAM_read_data_i;
   assign gnt_o     = gnt;
   assign owner_o   = owner;
   assign busy_o    = (|gnt) || pipe_busy;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a small latency-2 SRAM model.
module tb_sram_access_arbiter;

   logic              clk;
   logic              resetn;
   logic [3:0]        req;
   logic [3:0]        we_n;
   logic [3:0][17:0]  addr;
   logic [3:0][15:0]  wdat;
   logic [3:0]        gnt;
   logic [3:0]        rdv;
   logic [15:0]       rdd;
   logic [17:0]       sa;
   logic [15:0]       swd;
   logic              swe;
   logic [15:0]       srd;
   logic [1:0]        owner;
   logic              busy;

   int total = 0;
   int bad   = 0;

   sram_access_arbiter #(.NUM_REQ(4), .READ_LATENCY(2), .MAX_BURST(4)) dut (
      .CLOCK_50_I        (clk),
      .resetn            (resetn),
      .req_i             (req),
      .req_we_n_i        (we_n),
      .req_address_i     (addr),
      .req_write_data_i  (wdat),
      .gnt_o             (gnt),
      .rd_valid_o        (rdv),
      .rd_data_o         (rdd),
      .SRAM_address_o    (sa),
      .SRAM_write_data_o (swd),
      .SRAM_we_n_o       (swe),
      .SRAM_read_data_i  (srd),
      .owner_o           (owner),
      .busy_o            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: data for the address presented in cycle n appears in cycle n+2.
   logic [17:0] a1, a2;
   always @(posedge clk) begin
      a1 <= sa;
      a2 <= a1;
   end
   assign srd = a2[15:0] ^ 16'h5A5A;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic sample;
      @(negedge clk);
   endtask

   task automatic test_reset;
      #3;
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      total++; if (rdv !== 4'b0000) begin bad++; $display("FAIL reset_rdv: got %b want 0000", rdv); end
      total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner: got %0d want 0", owner); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (swe !== 1'b1 || sa !== 18'h0 || swd !== 16'h0) begin bad++; $display("FAIL reset_bus: got we_n=%b a=%h d=%h want 1/0/0", swe, sa, swd); end
      step; resetn = 1'b1;
      sample;
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_idle_gnt: got %b want 0000", gnt); end
   endtask

   task automatic test_single_read;
      step; req = 4'b0001; addr[0] = 18'h00010; we_n = 4'hF; sample;
      total++; if (gnt !== 4'b0000 || swe !== 1'b1) begin bad++; $display("FAIL single_c0: got gnt=%b we_n=%b want 0000/1", gnt, swe); end
      step; sample;
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b want 0001", gnt); end
      total++; if (sa !== 18'h00010 || swe !== 1'b1) begin bad++; $display("FAIL single_rd0: got a=%h we_n=%b want 00010/1", sa, swe); end
      step; addr[0] = 18'h00011; sample;
      total++; if (sa !== 18'h00011 || rdv !== 4'b0000) begin bad++; $display("FAIL single_rd1: got a=%h rdv=%b want 00011/0000", sa, rdv); end
      step; req = 4'b0000; sample;
      total++; if (rdv !== 4'b0001 || rdd !== 16'h5A4A) begin bad++; $display("FAIL single_ret0: got rdv=%b d=%h want 0001/5a4a", rdv, rdd); end
      total++; if (swe !== 1'b1 || sa !== 18'h0) begin bad++; $display("FAIL single_drop_bus: got we_n=%b a=%h want 1/0", swe, sa); end
      step; sample;
      total++; if (rdv !== 4'b0001 || rdd !== 16'h5A4B) begin bad++; $display("FAIL single_ret1: got rdv=%b d=%h want 0001/5a4b", rdv, rdd); end
      total++; if (gnt !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL single_release: got gnt=%b busy=%b want 0000/1", gnt, busy); end
      step; sample;
      total++; if (rdv !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL single_quiet: got rdv=%b busy=%b want 0000/0", rdv, busy); end
   endtask

   task automatic test_collision;
      step; req = 4'b1010; addr[1] = 18'h00100; addr[3] = 18'h00300; sample;
      step; sample;
      total++; if (gnt !== 4'b0010 || owner !== 2'd1) begin bad++; $display("FAIL coll_gnt: got gnt=%b owner=%0d want 0010/1", gnt, owner); end
      total++; if (sa !== 18'h00100) begin bad++; $display("FAIL coll_addr: got %h want 00100", sa); end
      step; req = 4'b1000; sample;
      total++; if (gnt !== 4'b0010 || swe !== 1'b1 || sa !== 18'h0) begin bad++; $display("FAIL coll_drop: got gnt=%b we_n=%b a=%h want 0010/1/0", gnt, swe, sa); end
      step; sample;
      total++; if (gnt !== 4'b0000 || swe !== 1'b1 || sa !== 18'h0) begin bad++; $display("FAIL coll_gap: got gnt=%b we_n=%b a=%h want 0000/1/0", gnt, swe, sa); end
      total++; if (rdv !== 4'b0010 || rdd !== 16'h5B5A) begin bad++; $display("FAIL coll_m1_ret: got rdv=%b d=%h want 0010/5b5a", rdv, rdd); end
      step; sample;
      total++; if (gnt !== 4'b1000 || owner !== 2'd3 || sa !== 18'h00300) begin bad++; $display("FAIL coll_vga: got gnt=%b owner=%0d a=%h want 1000/3/00300", gnt, owner, sa); end
      step; req = 4'b0000; sample;
      step; sample;
      total++; if (rdv !== 4'b1000 || rdd !== 16'h595A) begin bad++; $display("FAIL coll_vga_ret: got rdv=%b d=%h want 1000/595a", rdv, rdd); end
      step; sample;
   endtask

   task automatic test_owner_change;
      step; req = 4'b0010; addr[1] = 18'h00200; sample;
      step; req = 4'b1010; we_n = 4'b0111; addr[3] = 18'h003AA; wdat[3] = 16'h7777; sample;
      total++; if (gnt !== 4'b0010 || sa !== 18'h00200) begin bad++; $display("FAIL oc_m1: got gnt=%b a=%h want 0010/00200", gnt, sa); end
      step; addr[1] = 18'h00201; sample;
      total++; if (sa !== 18'h00201 || swe !== 1'b1) begin bad++; $display("FAIL oc_last_rd: got a=%h we_n=%b want 00201/1", sa, swe); end
      step; req = 4'b1000; sample;
      total++; if (rdv !== 4'b0010 || rdd !== 16'h585A) begin bad++; $display("FAIL oc_ret0: got rdv=%b d=%h want 0010/585a", rdv, rdd); end
      step; sample;
      total++; if (rdv !== 4'b0010 || rdd !== 16'h585B) begin bad++; $display("FAIL oc_ret1: got rdv=%b d=%h want 0010/585b", rdv, rdd); end
      step; sample;
      total++; if (gnt !== 4'b1000 || swe !== 1'b0 || sa !== 18'h003AA || swd !== 16'h7777) begin bad++; $display("FAIL oc_vga_wr: got gnt=%b we_n=%b a=%h d=%h want 1000/0/003aa/7777", gnt, swe, sa, swd); end
      total++; if (rdv !== 4'b0000) begin bad++; $display("FAIL oc_rdv_c5: got %b want 0000", rdv); end
      step; req = 4'b0000; we_n = 4'hF; sample;
      step; sample;
      total++; if (rdv !== 4'b0000) begin bad++; $display("FAIL oc_no_vga_rd: got %b want 0000", rdv); end
      step; sample;
   endtask

   task automatic test_forced_release;
      int n;
      n = 0;
      step; req = 4'b0100; addr[2] = 18'h00400; sample;
      step; req = 4'b0101; addr[0] = 18'h00050; wdat[0] = 16'h1111; we_n = 4'b1110; sample;
      if (gnt == 4'b0100 && sa == 18'h00400 && swe == 1'b1) n++;
      repeat (5) begin
         step; sample;
         if (gnt == 4'b0100 && sa == 18'h00400 && swe == 1'b1) n++;
      end
      total++; if (n != 4) begin bad++; $display("FAIL force_count: got %0d accesses want 4", n); end
      total++; if (gnt !== 4'b0000 || swe !== 1'b1) begin bad++; $display("FAIL force_gap: got gnt=%b we_n=%b want 0000/1", gnt, swe); end
      step; sample;
      total++; if (gnt !== 4'b0001 || owner !== 2'd0) begin bad++; $display("FAIL force_uart: got gnt=%b owner=%0d want 0001/0", gnt, owner); end
      total++; if (swe !== 1'b0 || sa !== 18'h00050 || swd !== 16'h1111) begin bad++; $display("FAIL force_uart_wr: got we_n=%b a=%h d=%h want 0/00050/1111", swe, sa, swd); end
      step; req = 4'b0100; sample;
      step; sample;
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL force_uart_rel: got %b want 0000", gnt); end
      step; sample;
      total++; if (gnt !== 4'b0100 || sa !== 18'h00400) begin bad++; $display("FAIL force_regrant: got gnt=%b a=%h want 0100/00400", gnt, sa); end
      step; req = 4'b0000; we_n = 4'hF; sample;
      step; sample;
      step; sample;
   endtask

   task automatic test_force_mask;
      int n;
      n = 0;
      step; req = 4'b1010; addr[1] = 18'h00111; addr[3] = 18'h00333; sample;
      repeat (6) begin
         step; sample;
         if (gnt == 4'b0010 && sa == 18'h00111) n++;
      end
      total++; if (n != 4) begin bad++; $display("FAIL mask_count: got %0d accesses want 4", n); end
      total++; if (gnt !== 4'b0000 || rdv !== 4'b0010) begin bad++; $display("FAIL mask_gap: got gnt=%b rdv=%b want 0000/0010", gnt, rdv); end
      step; sample;
      total++; if (gnt !== 4'b1000 || owner !== 2'd3) begin bad++; $display("FAIL mask_vga: got gnt=%b owner=%0d want 1000/3", gnt, owner); end
      step; req = 4'b0000; sample;
      step; sample;
      total++; if (rdv !== 4'b1000) begin bad++; $display("FAIL mask_vga_ret: got %b want 1000", rdv); end
      step; sample;
   endtask

   task automatic test_write;
      step; req = 4'b0010; we_n = 4'b1101; addr[1] = 18'h25000; wdat[1] = 16'hABCD; sample;
      step; sample;
      total++; if (gnt !== 4'b0010 || swe !== 1'b0) begin bad++; $display("FAIL wr_we: got gnt=%b we_n=%b want 0010/0", gnt, swe); end
      total++; if (sa !== 18'h25000 || swd !== 16'hABCD) begin bad++; $display("FAIL wr_bus: got a=%h d=%h want 25000/abcd", sa, swd); end
      step; req = 4'b0000; we_n = 4'hF; sample;
      total++; if (rdv !== 4'b0000) begin bad++; $display("FAIL wr_rdv_c2: got %b want 0000", rdv); end
      step; sample;
      total++; if (rdv !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL wr_rdv_c3: got rdv=%b busy=%b want 0000/0", rdv, busy); end
   endtask

   task automatic test_async_reset;
      step; req = 4'b0001; addr[0] = 18'h00010; sample;
      step; sample;
      step; addr[0] = 18'h00011; sample;
      total++; if (busy !== 1'b1 || gnt !== 4'b0001) begin bad++; $display("FAIL ar_pre: got busy=%b gnt=%b want 1/0001", busy, gnt); end
      #1; resetn = 1'b0; req = 4'b0000;
      #1;
      total++; if (gnt !== 4'b0000 || swe !== 1'b1 || sa !== 18'h0) begin bad++; $display("FAIL ar_async: got gnt=%b we_n=%b a=%h want 0000/1/0", gnt, swe, sa); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %b want 0", busy); end
      step; resetn = 1'b1; sample;
      total++; if (rdv !== 4'b0000) begin bad++; $display("FAIL ar_rdv_c3: got %b want 0000", rdv); end
      step; sample;
      total++; if (rdv !== 4'b0000) begin bad++; $display("FAIL ar_rdv_c4: got %b want 0000", rdv); end
      step; sample;
      total++; if (rdv !== 4'b0000 || gnt !== 4'b0000) begin bad++; $display("FAIL ar_quiet: got rdv=%b gnt=%b want 0000/0000", rdv, gnt); end
   endtask

   initial begin
      resetn = 1'b0;
      req    = 4'b0000;
      we_n   = 4'hF;
      addr   = '0;
      wdat   = '0;
      test_reset;
      test_single_read;
      test_collision;
      test_owner_change;
      test_forced_release;
      test_force_mask;
      test_write;
      test_async_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
